// File: rtl/pwm_decoder.sv
// Servo PWM high-time decoder: measures one pulse channel and converts its width to a
// 10-bit code = min((width - MIN_CYCLES) / STEP_CYCLES, MAX_CODE), with a signal-loss failsafe.
module pwm_decoder #(
  parameter int unsigned MIN_CYCLES       = 50000,
  parameter int unsigned STEP_CYCLES      = 50,
  parameter int unsigned MAX_CODE         = 1023,
  parameter int unsigned GLITCH_CYCLES    = 25000,
  parameter int unsigned MAX_PULSE_CYCLES = 125000,
  parameter int unsigned TIMEOUT_CYCLES   = 1500000,
  parameter int unsigned FAILSAFE_CODE    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [9:0] control,
  output logic       valid,
  output logic       signal_ok,
  output logic [1:0] dbg_state
);

  // Handshake: valid is a one-cycle strobe with no ready; control is stable whenever
  // valid is high and holds its value until the next accepted pulse or the failsafe.

  localparam int unsigned PW = $clog2(STEP_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [16:0]   MIN_W    = 17'(MIN_CYCLES);
  localparam logic [16:0]   GLITCH_W = 17'(GLITCH_CYCLES);
  localparam logic [16:0]   MAXP_W   = 17'(MAX_PULSE_CYCLES);
  localparam logic [16:0]   ABORT_W  = 17'(MAX_PULSE_CYCLES + 1);
  localparam logic [PW-1:0] STEP_L   = PW'(STEP_CYCLES - 1);
  localparam logic [9:0]    MAX_C    = 10'(MAX_CODE);
  localparam logic [9:0]    FS_C     = 10'(FAILSAFE_CODE);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q, dly_q;
  logic [1:0]    fill_q;
  logic [16:0]   width_q, width_d, width_inc;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    acc_q, acc_d;
  logic [TW-1:0] to_q, to_d;
  logic [9:0]    control_q, control_d;
  logic          valid_q, valid_d;
  logic          ok_q, ok_d;
  logic          rise, primed;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dly_q     <= 1'b0;
      fill_q    <= 2'd0;
      state_q   <= SYNC;
      width_q   <= '0;
      presc_q   <= '0;
      acc_q     <= '0;
      to_q      <= '0;
      control_q <= '0;
      valid_q   <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      s1_q      <= pwm_in;
      s2_q      <= s1_q;
      dly_q     <= s2_q;
      fill_q    <= (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
      state_q   <= state_d;
      width_q   <= width_d;
      presc_q   <= presc_d;
      acc_q     <= acc_d;
      to_q      <= to_d;
      control_q <= control_d;
      valid_q   <= valid_d;
      ok_q      <= ok_d;
    end
  end

  assign rise      = s2_q & ~dly_q;
  // The synchronizer holds reset zeros for two cycles; a high line must not look low then.
  assign primed    = fill_q[1];
  assign width_inc = (width_q == 17'h1ffff) ? width_q : width_q + 17'd1;

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    presc_d   = presc_q;
    acc_d     = acc_q;
    to_d      = to_q;
    control_d = control_q;
    valid_d   = 1'b0;
    ok_d      = ok_q;

    if (to_q != TO_MAX) to_d = to_q + TW'(1);
    if (to_q == TO_LAST) begin
      ok_d      = 1'b0;
      control_d = FS_C;
    end

    case (state_q)
      SYNC: begin
        if (primed && !s2_q) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          width_d = 17'd1;
          presc_d = '0;
          acc_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (s2_q) begin
          width_d = width_inc;
          if (width_q >= MIN_W) begin
            if (presc_q == STEP_L) begin
              presc_d = '0;
              if (acc_q != MAX_C) acc_d = acc_q + 10'd1;
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
          if (width_inc == ABORT_W) state_d = SYNC;
        end else begin
          // Acceptance is evaluated after the timeout so it wins a same-cycle collision.
          if (width_q >= GLITCH_W && width_q <= MAXP_W) begin
            control_d = acc_q;
            valid_d   = 1'b1;
            ok_d      = 1'b1;
            to_d      = '0;
          end
          state_d = WAIT_RISE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign control   = control_q;
  assign valid     = valid_q;
  assign signal_ok = ok_q;
  assign dbg_state = state_q;

endmodule
